// File: rtl/shift_arbiter_ctrl.sv
// Round-robin arbiter that shares one combinational barrel shifter between two requesters.
// Operands are registered onto the shifter inputs, and the shifter output is captured one cycle later.
module shift_arbiter_ctrl #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [SHW-1:0]   sh0,
    input  logic [WIDTH-1:0] rt0,
    input  logic [WIDTH-1:0] rs0,
    input  logic             regimm0,
    input  logic             lr0,
    input  logic             al0,
    input  logic             req1,
    input  logic [SHW-1:0]   sh1,
    input  logic [WIDTH-1:0] rt1,
    input  logic [WIDTH-1:0] rs1,
    input  logic             regimm1,
    input  logic             lr1,
    input  logic             al1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [SHW-1:0]   shf_sh,
    output logic [WIDTH-1:0] shf_rt,
    output logic [WIDTH-1:0] shf_rs,
    output logic             shf_regimm,
    output logic             shf_lr,
    output logic             shf_al,
    input  logic [WIDTH-1:0] shf_out
);

    // state   | meaning
    // IDLE    | waiting for a request; arbitrates and latches operands on grant
    // ISSUE   | operand registers drive the shifter; ack pulse to the owner
    // CAPTURE | result holds the captured shifter output; done pulse to the owner
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t state;
    logic   owner;
    logic   ptr;
    logic   win;

    // A lone requester wins outright; under contention the pointer decides.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) win = ptr;
        else              win = req1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            ptr        <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            busy       <= 1'b0;
            result     <= '0;
            shf_sh     <= '0;
            shf_rt     <= '0;
            shf_rs     <= '0;
            shf_regimm <= 1'b0;
            shf_lr     <= 1'b0;
            shf_al     <= 1'b0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner <= win;
                        ptr   <= ~win;
                        ack0  <= ~win;
                        ack1  <= win;
                        busy  <= 1'b1;
                        state <= ISSUE;
                        if (win) begin
                            shf_sh     <= sh1;
                            shf_rt     <= rt1;
                            shf_rs     <= rs1;
                            shf_regimm <= regimm1;
                            shf_lr     <= lr1;
                            shf_al     <= al1;
                        end else begin
                            shf_sh     <= sh0;
                            shf_rt     <= rt0;
                            shf_rs     <= rs0;
                            shf_regimm <= regimm0;
                            shf_lr     <= lr0;
                            shf_al     <= al0;
                        end
                    end
                end
                ISSUE: begin
                    result <= shf_out;
                    done0  <= ~owner;
                    done1  <= owner;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Scoreboard bench for shift_arbiter_ctrl with a behavioural barrel shifter on the shf_* port.
// Directed stimulus pushes expected ack owners and results; a negedge monitor pops and compares.
module tb_shift_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [4:0]  sh0, sh1;
    logic [31:0] rt0, rs0, rt1, rs1;
    logic        regimm0, lr0, al0, regimm1, lr1, al1;
    logic        ack0, ack1, done0, done1, busy;
    logic [31:0] result;
    logic [4:0]  shf_sh;
    logic [31:0] shf_rt, shf_rs, shf_out;
    logic        shf_regimm, shf_lr, shf_al;

    int n_checks = 0;
    int n_pass   = 0;

    logic        ack_q[$];
    logic [32:0] done_q[$];

    always #5 clk = ~clk;

    shift_arbiter_ctrl #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .sh0(sh0), .rt0(rt0), .rs0(rs0),
        .regimm0(regimm0), .lr0(lr0), .al0(al0),
        .req1(req1), .sh1(sh1), .rt1(rt1), .rs1(rs1),
        .regimm1(regimm1), .lr1(lr1), .al1(al1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .result(result), .busy(busy),
        .shf_sh(shf_sh), .shf_rt(shf_rt), .shf_rs(shf_rs),
        .shf_regimm(shf_regimm), .shf_lr(shf_lr), .shf_al(shf_al),
        .shf_out(shf_out)
    );

    // Reference barrel shifter
    logic [4:0] amt;
    always_comb begin
        amt = shf_regimm ? shf_rs[4:0] : shf_sh;
        if (shf_lr)      shf_out = shf_rt << amt;
        else if (shf_al) shf_out = $unsigned($signed(shf_rt) >>> amt);
        else             shf_out = shf_rt >> amt;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (ack0 || ack1 || done0 || done1)
                chk("one_hot_hs", 32'(ack0) + 32'(ack1) + 32'(done0) + 32'(done1), 32'd1);
            if (ack0 || ack1) begin
                if (ack_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL ack_unexpected: got ack0=%b ack1=%b expected none", ack0, ack1);
                end else begin
                    logic e;
                    e = ack_q.pop_front();
                    chk("ack_owner", 32'(ack1), 32'(e));
                end
            end
            if (done0 || done1) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL done_unexpected: got done0=%b done1=%b result=%h expected none",
                             done0, done1, result);
                end else begin
                    logic [32:0] d;
                    d = done_q.pop_front();
                    chk("done_owner", 32'(done1), 32'(d[32]));
                    chk("done_result", result, d[31:0]);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_contention_ops();
        sh0 = 5'd8; rt0 = 32'h12345678; rs0 = 32'h0; regimm0 = 1'b0; lr0 = 1'b1; al0 = 1'b0;
        sh1 = 5'd4; rt1 = 32'h80000000; rs1 = 32'h0; regimm1 = 1'b0; lr1 = 1'b0; al1 = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        sh0 = '0; sh1 = '0; rt0 = '0; rt1 = '0; rs0 = '0; rs1 = '0;
        regimm0 = 1'b0; lr0 = 1'b0; al0 = 1'b0;
        regimm1 = 1'b0; lr1 = 1'b0; al1 = 1'b0;
        repeat (2) next_cycle();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_shf_rt", shf_rt, 32'd0);
        chk("rst_hs", 32'({ack0, ack1, done0, done1}), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // Single request, arithmetic right by immediate; rs0 would give a different answer
        sh0 = 5'd5; rt0 = 32'hFFFFFE0C; rs0 = 32'h0000001F; regimm0 = 1'b0; lr0 = 1'b0; al0 = 1'b1;
        req0 = 1'b1;
        ack_q.push_back(1'b0);
        done_q.push_back({1'b0, 32'hFFFFFFF0});
        next_cycle();
        chk("t1_ack0", 32'(ack0), 32'd1);
        chk("t1_busy_issue", 32'(busy), 32'd1);
        chk("t1_shf_rt", shf_rt, 32'hFFFFFE0C);
        chk("t1_shf_sh", 32'(shf_sh), 32'd5);
        chk("t1_shf_ctl", 32'({shf_regimm, shf_lr, shf_al}), 32'd1);
        req0 = 1'b0;
        next_cycle();
        chk("t1_done0", 32'(done0), 32'd1);
        chk("t1_result", result, 32'hFFFFFFF0);
        chk("t1_busy_capture", 32'(busy), 32'd1);
        next_cycle();
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // Register-sourced left shift by requester 1
        sh1 = 5'd3; rt1 = 32'd7; rs1 = 32'h00000024; regimm1 = 1'b1; lr1 = 1'b1; al1 = 1'b0;
        req1 = 1'b1;
        ack_q.push_back(1'b1);
        done_q.push_back({1'b1, 32'h00000070});
        next_cycle();
        chk("t2_ack1", 32'(ack1), 32'd1);
        chk("t2_ack0", 32'(ack0), 32'd0);
        req1 = 1'b0;
        next_cycle();
        chk("t2_done1", 32'(done1), 32'd1);
        chk("t2_done0", 32'(done0), 32'd0);
        chk("t2_result", result, 32'h00000070);
        next_cycle();

        // Contention for 12 edges: grants 0,1,0,1
        set_contention_ops();
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ack_q.push_back(1'b0);
            done_q.push_back({1'b0, 32'h34567800});
            ack_q.push_back(1'b1);
            done_q.push_back({1'b1, 32'hF8000000});
        end
        repeat (12) next_cycle();
        req0 = 1'b0; req1 = 1'b0;
        chk("t3_drained", 32'(done_q.size()), 32'd0);

        // Lone requester re-granted every third cycle even though the pointer names requester 1
        sh0 = 5'd12; rt0 = 32'h0000F000; rs0 = 32'h0; regimm0 = 1'b0; lr0 = 1'b0; al0 = 1'b0;
        req0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ack_q.push_back(1'b0);
            done_q.push_back({1'b0, 32'h0000000F});
        end
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            chk("t4_ack0_cycle", 32'(ack0), (i % 3 == 0) ? 32'd1 : 32'd0);
        end
        req0 = 1'b0;

        // Reset during ISSUE: immediate clear, no done afterwards
        sh0 = 5'd1; rt0 = 32'hAAAA5555; regimm0 = 1'b0; lr0 = 1'b1; al0 = 1'b0;
        req0 = 1'b1;
        next_cycle();
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        chk("t5_ack0_cleared", 32'(ack0), 32'd0);
        chk("t5_busy_cleared", 32'(busy), 32'd0);
        chk("t5_result_cleared", result, 32'd0);
        chk("t5_shf_rt_cleared", shf_rt, 32'd0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        repeat (3) next_cycle();
        chk("t5_busy_after", 32'(busy), 32'd0);
        chk("t5_result_after", result, 32'd0);
        set_contention_ops();
        req0 = 1'b1; req1 = 1'b1;
        ack_q.push_back(1'b0);
        done_q.push_back({1'b0, 32'h34567800});
        ack_q.push_back(1'b1);
        done_q.push_back({1'b1, 32'hF8000000});
        repeat (6) next_cycle();
        req0 = 1'b0; req1 = 1'b0;
        next_cycle();

        // Idle input changes must not reach the shifter or the result
        rt0 = 32'hDEADBEEF; rt1 = 32'hCAFEF00D; sh0 = 5'd17; sh1 = 5'd9;
        lr1 = 1'b1; regimm1 = 1'b1; rs1 = 32'h3;
        repeat (4) next_cycle();
        chk("t6_shf_rt_hold", shf_rt, 32'h80000000);
        chk("t6_shf_sh_hold", 32'(shf_sh), 32'd4);
        chk("t6_result_hold", result, 32'hF8000000);
        chk("t6_busy", 32'(busy), 32'd0);

        chk("end_ack_q_empty", 32'(ack_q.size()), 32'd0);
        chk("end_done_q_empty", 32'(done_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
